obi_port_arbiter: RTL and testbench

- Shares one OBI-style memory port between the core's instruction-fetch requester and data-memory requester.
- Sits between the core's `imem_interface`/`dmem_interface` and a unified single-port memory or bus bridge.
- Tracks the single outstanding transaction, routes the response back to its owner, and synthesises an error response if the memory never answers.

---
 rtl/obi_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_obi_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_port_arbiter.sv
// Two-requester arbiter sharing one OBI-style memory port between instruction fetch and data access.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate ties between requesters instead of data-first priority.
module obi_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i,

  output logic        busy_o,
  output logic        owner_o,
  output logic        timeout_o,
  output logic        stray_rsp_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic        TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  localparam logic OWN_INSTR = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [15:0] cnt_q, cnt_d;
  logic        stray_q, stray_d;

  logic sel;
  logic busy;
  logic issue_ok;
  logic req_out;
  logic granted;
  logic rsp_hit;
  logic to_hit;
  logic rsp_valid;
  logic rsp_err;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On a tie the requester that did not win the previous grant goes first.
  always_comb begin
    if (instr_req_i && data_req_i) begin
      sel = ~last_q;
    end else begin
      sel = data_req_i;
    end
  end

  always_comb begin
    last_d = granted ? sel : last_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= OWN_INSTR;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    sel = data_req_i ? OWN_DATA : OWN_INSTR;
  end
`endif

  assign busy     = (state_q == ST_BUSY);
  assign rsp_hit  = busy && mem_rvalid_i;
  assign to_hit   = TO_EN && busy && !mem_rvalid_i && (cnt_q == TO_LAST);
  // A new request may go out in IDLE, or in BUSY when the pending response retires this cycle.
  assign issue_ok = !busy || mem_rvalid_i;
  // NOTE: the request path is combinational from the inputs, so it is gated by rst_ni to hold
  // every output at 0 while reset is asserted, even if a requester is already active.
  assign req_out  = rst_ni && issue_ok && (instr_req_i || data_req_i);
  assign granted  = req_out && mem_gnt_i;

  always_comb begin
    mem_req_o   = req_out;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (req_out) begin
      if (sel == OWN_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign instr_gnt_o = granted && (sel == OWN_INSTR);
  assign data_gnt_o  = granted && (sel == OWN_DATA);

  // A synthetic timeout response always reports an error and carries zero data.
  assign rsp_valid = rsp_hit || to_hit;
  assign rsp_err   = to_hit ? 1'b1 : mem_err_i;

  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_err_o    = 1'b0;
    data_rvalid_o  = 1'b0;
    data_err_o     = 1'b0;
    instr_rdata_o  = rsp_hit ? mem_rdata_i : 32'h0;
    data_rdata_o   = rsp_hit ? mem_rdata_i : 32'h0;
    if (rsp_valid) begin
      if (owner_q == OWN_DATA) begin
        data_rvalid_o  = 1'b1;
        data_err_o     = rsp_err;
      end else begin
        instr_rvalid_o = 1'b1;
        instr_err_o    = rsp_err;
      end
    end
  end

  assign timeout_o   = to_hit;
  assign busy_o      = busy;
  assign owner_o     = owner_q;
  assign stray_rsp_o = stray_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    stray_d = stray_q | (!busy && mem_rvalid_i);
    if (granted) begin
      state_d = ST_BUSY;
      owner_d = sel;
      cnt_d   = 16'd0;
    end else if (rsp_valid) begin
      state_d = ST_IDLE;
    end else if (busy && (cnt_q != 16'hFFFF)) begin
      cnt_d   = cnt_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_INSTR;
      cnt_q   <= 16'd0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      stray_q <= stray_d;
    end
  end

endmodule

// File: tb/tb_obi_port_arbiter.sv
// Directed self-checking bench for obi_port_arbiter, built with a short response timeout of 8 cycles.
module tb_obi_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_rdata;
  logic        data_req = 1'b0, data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy, owner, timeout, stray;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  obi_port_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_err_i(mem_err), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .owner_o(owner), .timeout_o(timeout), .stray_rsp_o(stray)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then changed and outputs sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
  endtask

  logic exp_data [4];
  int   gnt_pulses;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_data[0] = 1'b1; exp_data[1] = 1'b0; exp_data[2] = 1'b1; exp_data[3] = 1'b0;
`else
    exp_data[0] = 1'b1; exp_data[1] = 1'b1; exp_data[2] = 1'b1; exp_data[3] = 1'b1;
`endif

    // Reset with a live request: everything must stay 0.
    instr_req = 1'b1; instr_addr = 32'h0000_0100;
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_instr_gnt", instr_gnt, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_busy", busy, 0);
    check("rst_stray", stray, 0);
    instr_req = 1'b0;
    cyc();
    rst_n = 1'b1;

    // Single instruction fetch.
    cyc();
    instr_req = 1'b1; instr_addr = 32'h0000_0100; mem_gnt = 1'b1;
    #1;
    check("if_mem_req", mem_req, 1);
    check("if_mem_addr", mem_addr, 32'h100);
    check("if_mem_be", mem_be, 4'hF);
    check("if_mem_we", mem_we, 0);
    check("if_instr_gnt", instr_gnt, 1);
    check("if_data_gnt", data_gnt, 0);
    cyc();
    idle_inputs(); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("if_busy", busy, 1);
    check("if_owner", owner, 0);
    check("if_instr_rvalid", instr_rvalid, 1);
    check("if_instr_rdata", instr_rdata, 32'hDEAD_BEEF);
    check("if_data_rvalid", data_rvalid, 0);
    cyc();
    idle_inputs();
    #1;
    check("if_idle", busy, 0);

    // Both requesters held across four back-to-back transactions.
    data_we = 1'b1; data_be = 4'h3; data_wdata = 32'h1234; data_addr = 32'h200;
    instr_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      cyc();
      instr_req = 1'b1; data_req = 1'b1; data_we = 1'b1; mem_gnt = 1'b1;
      mem_rvalid = (i > 0); mem_rdata = 32'(i);
      #1;
      check($sformatf("tie%0d_data_gnt", i), data_gnt, 32'(exp_data[i]));
      check($sformatf("tie%0d_instr_gnt", i), instr_gnt, 32'(!exp_data[i]));
      if (exp_data[i]) begin
        check($sformatf("tie%0d_we", i), mem_we, 1);
        check($sformatf("tie%0d_be", i), mem_be, 4'h3);
        check($sformatf("tie%0d_wdata", i), mem_wdata, 32'h1234);
      end else begin
        check($sformatf("tie%0d_be", i), mem_be, 4'hF);
        check($sformatf("tie%0d_addr", i), mem_addr, 32'h300);
      end
      if (i > 0) begin
        check($sformatf("tie%0d_busy", i), busy, 1);
        check($sformatf("tie%0d_drv", i), data_rvalid, 32'(exp_data[i-1]));
        check($sformatf("tie%0d_irv", i), instr_rvalid, 32'(!exp_data[i-1]));
      end
    end
    cyc();
    idle_inputs(); mem_rvalid = 1'b1; mem_rdata = 32'h3;
    #1;
    check("tie_last_owner", owner, 32'(exp_data[3]));
    check("tie_last_drv", data_rvalid, 32'(exp_data[3]));
    cyc();
    idle_inputs();
    #1;
    check("tie_idle", busy, 0);

    // Back-to-back ownership change: data read A, then instr B granted with A's response.
    data_we = 1'b0; data_be = 4'hF; data_addr = 32'h400;
    data_req = 1'b1; mem_gnt = 1'b1;
    #1;
    check("b2b_a_gnt", data_gnt, 1);
    cyc();
    idle_inputs();
    instr_req = 1'b1; instr_addr = 32'h500; mem_gnt = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    #1;
    check("b2b_a_drv", data_rvalid, 1);
    check("b2b_a_rdata", data_rdata, 32'hA5A5_A5A5);
    check("b2b_a_irv", instr_rvalid, 0);
    check("b2b_b_gnt", instr_gnt, 1);
    check("b2b_b_addr", mem_addr, 32'h500);
    cyc();
    idle_inputs(); mem_rvalid = 1'b1; mem_rdata = 32'h11;
    #1;
    check("b2b_busy", busy, 1);
    check("b2b_owner", owner, 0);
    check("b2b_b_irv", instr_rvalid, 1);
    check("b2b_b_drv", data_rvalid, 0);
    cyc();
    idle_inputs();

    // Grant stall: three cycles without grant, then grant.
    gnt_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      instr_req = 1'b1; instr_addr = 32'h600; mem_gnt = (i == 3);
      #1;
      check($sformatf("stall%0d_req", i), mem_req, 1);
      check($sformatf("stall%0d_addr", i), mem_addr, 32'h600);
      if (instr_gnt) gnt_pulses++;
      cyc();
    end
    idle_inputs();
    #1;
    if (instr_gnt) gnt_pulses++;
    check("stall_busy", busy, 1);
    check("stall_gnt_pulses", gnt_pulses, 1);
    mem_rvalid = 1'b1;
    #1;
    check("stall_irv", instr_rvalid, 1);
    cyc();
    idle_inputs();

    // Timeout on a data read that memory never answers.
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h700; mem_gnt = 1'b1;
    #1;
    check("to_gnt", data_gnt, 1);
    cyc();
    idle_inputs(); instr_req = 1'b1; mem_gnt = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      #1;
      check($sformatf("to_wait%0d_drv", k), data_rvalid, 0);
      check($sformatf("to_wait%0d_req", k), mem_req, 0);
      cyc();
    end
    #1;
    check("to_drv", data_rvalid, 1);
    check("to_derr", data_err, 1);
    check("to_rdata", data_rdata, 0);
    check("to_pulse", timeout, 1);
    check("to_no_issue", mem_req, 0);
    cyc();
    idle_inputs();
    #1;
    check("to_idle", busy, 0);
    check("to_pulse_end", timeout, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    #1;
    check("late_drv", data_rvalid, 0);
    check("late_irv", instr_rvalid, 0);
    cyc();
    idle_inputs();
    #1;
    check("late_stray", stray, 1);

    // Reset while BUSY abandons the transaction.
    instr_req = 1'b1; instr_addr = 32'h800; mem_gnt = 1'b1;
    cyc();
    #1;
    check("rb_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rb_mem_req", mem_req, 0);
    check("rb_instr_gnt", instr_gnt, 0);
    check("rb_busy", busy, 0);
    check("rb_stray", stray, 0);
    idle_inputs();
    cyc();
    rst_n = 1'b1;
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h66;
    #1;
    check("rb_late_irv", instr_rvalid, 0);
    cyc();
    idle_inputs();
    #1;
    check("rb_late_stray", stray, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
